alu_seq_muldiv: RTL
===================

# alu_seq_muldiv

Iterative signed multiply/divide/modulo unit that serves the G1Mul, G1Div and G1Mod operations of the G1 ALU opcode set as a multi-cycle responder. A requester presents operands and an opcode with a start pulse. The block computes the result over a fixed number of cycles with a shift/add and restoring-division datapath, then returns the result and Z/N/V/C flags with a one-cycle done pulse. It sits beside the single-cycle ALU in the execute stage and takes over the long-latency operations.

## Interface
- No parameters; datapath width is fixed at 32 bits and the iteration count is fixed at 32.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- reg1  in  32  signed operand A (multiplicand / dividend)
- reg2  in  32  signed operand B (multiplier / divisor)
- operation  in  4  4'b0010 = G1Mul, 4'b0011 = G1Div, 4'b0100 = G1Mod
- busy  out  1  high from the cycle after acceptance until done falls
- done  out  1  one-cycle pulse; result and flags are valid from this cycle on
- result  out  32  signed result; held until the next done
- z_flag, n_flag, v_flag, c_flag  out  1 each  flags; held with result

## Operation
- FSM states: IDLE, PREP, CALC, FIX, DONE.
- IDLE: when start=1, latch reg1, reg2 and operation, then go to PREP. Inputs are ignored in every other state.
- PREP:
  - Latch sign(A), sign(B), |A| and |B| as 32-bit unsigned values; |0x80000000| = 0x80000000.
  - Flag divide-by-zero (reg2==0 with DIV/MOD).
  - Flag an illegal opcode (any value outside 0010/0011/0100).
  - Clear the 6-bit iteration counter, then go to CALC.
- CALC: run 32 iterations, one per cycle. Counter value 31 moves the FSM to FIX.
  - MUL: unsigned shift-add builds a 64-bit magnitude product.
  - DIV/MOD: unsigned restoring division produces quotient and remainder magnitudes.
- FIX: apply signs and register result and flags, then go to DONE.
  - MUL: result = low 32 bits of the signed 64-bit product.
    - c_flag = 1 if the high 32 bits of the magnitude product are nonzero.
    - v_flag = 1 if the signed 64-bit product is outside [-2^31, 2^31-1].
  - DIV: quotient truncates toward zero and is negative when sign(A)≠sign(B).
    - 0x80000000 / -1 gives result 0x80000000 with v_flag=1.
  - MOD: remainder takes the sign of A, so -13 % 5 = -3 and 13 % -5 = 3.
    - 0x80000000 % -1 = 0 with v_flag=0.
  - Divide-by-zero and illegal opcode: result=0; flags z=1, n=0, v=0, c=0.
  - All ops:
    - z_flag = (result==0).
    - n_flag = result[31].
    - c_flag = 0 for DIV and MOD.
    - v_flag = 0 except in the cases stated above.
- DONE: done=1 for one cycle, then return to IDLE. A start in this cycle is ignored; start is accepted in the following IDLE cycle.
- Reset, asynchronous at any time including mid-operation:
  - FSM returns to IDLE.
  - busy=0, done=0, result=0, all flags=0.
  - Internal registers and counter are cleared and any in-flight operation is discarded with no done.

## Timing
- start sampled high in IDLE at edge N. State is PREP after N, CALC after N+1, FIX after N+33, DONE after N+34.
- done is high in the single cycle following edge N+34, giving a fixed latency of 34 cycles for every opcode, including divide-by-zero and illegal opcodes.
- busy is high during the cycles following edges N through N+34 and low again after edge N+35.
- result and flags change only at edge N+34 and are stable otherwise.
- Earliest back-to-back start is at edge N+36, which makes throughput one operation per 36 cycles.
- Operand changes after edge N have no effect on the in-flight operation.

## Test plan
- MUL 3×4: start with reg1=3, reg2=4, op=0010 -> done exactly 34 cycles after acceptance; result=12, z=n=v=c=0. Then -7×6 -> result=-42, n=1, v=0, c=0.
- MUL overflow: 0x00010000×0x00010000 -> result=0, z=1, v=1, c=1, n=0. Then 0x80000000×-1 -> result=0x80000000, v=1, n=1.
- DIV: 8/2 -> result=4, all flags 0. Then 8/0 -> result=0, z=1, n=v=c=0. Then 0x80000000/-1 -> result=0x80000000, v=1, n=1.
- MOD: 13%5 -> result=3, all flags 0. Then -13%5 -> result=-3, n=1. Then 13%-5 -> result=3. Then 8%0 -> result=0, z=1.
- Protocol:
  - A second start during busy with different operands is ignored; the first result is returned.
  - A start in the DONE cycle is ignored.
  - op=4'b0111 completes after 34 cycles with result=0 and z=1.
- Reset mid-op: assert rst_n=0 between clock edges at CALC iteration 10 of 100×100 -> busy, done, result and flags go to 0 immediately, with no done pulse afterwards. A subsequent 3×4 returns 12 with normal latency.

Source files
------------

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative signed multiply / divide / modulo unit for the G1Mul, G1Div and G1Mod ops.
// Latency: a fixed 34 cycles from the accepting edge to done, for every opcode. Throughput is one op per 36 cycles.
// Backpressure: none. start is sampled only while idle. busy marks the window where requests are dropped.
//
// Ports:
//   clk, rst_n              rising-edge clock, asynchronous active-low reset
//   start                   request strobe (accepted only in IDLE)
//   reg1, reg2              signed operands A (multiplicand/dividend), B (multiplier/divisor)
//   operation               4'b0010 mul, 4'b0011 div, 4'b0100 mod; any other value is illegal
//   busy                    high from the cycle after acceptance until done falls
//   done                    one-cycle pulse when result/flags update
//   result, z/n/v/c_flag    registered result and flags, held until the next done
module alu_seq_muldiv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [3:0]  operation,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        z_flag,
  output logic        n_flag,
  output logic        v_flag,
  output logic        c_flag
);

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_MOD = 4'b0100;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;

  state_t      r_state;
  logic [31:0] r_a, r_b;
  logic [3:0]  r_op;
  logic        r_sa, r_sb;
  logic [31:0] r_absa, r_absb;
  logic        r_dz, r_ill;
  logic [5:0]  r_cnt;
  // Shared datapath: MUL uses {r_hi,r_lo} as product/multiplier shift register,
  // DIV/MOD use r_hi as partial remainder and r_lo as dividend/quotient.
  logic [31:0] r_hi, r_lo;
  logic        r_busy, r_done;
  logic [31:0] r_result;
  logic        r_z, r_n, r_v, r_c;

  logic        w_is_mul, w_is_div, w_is_mod;
  logic [31:0] w_absa, w_absb;
  logic [32:0] w_madd;
  logic [31:0] w_dshift, w_dsub;
  logic        w_ge;
  logic        w_pneg;
  logic [63:0] w_sprod;
  logic [31:0] w_quo, w_rem;
  logic [31:0] w_res;
  logic        w_v, w_c;

  assign w_is_mul = (r_op == OP_MUL);
  assign w_is_div = (r_op == OP_DIV);
  assign w_is_mod = (r_op == OP_MOD);

  // Two's-complement negate: |0x80000000| wraps to 0x80000000, which is the
  // correct unsigned magnitude.
  assign w_absa = r_a[31] ? (~r_a + 32'd1) : r_a;
  assign w_absb = r_b[31] ? (~r_b + 32'd1) : r_b;

  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit is set. The whole pair then shifts right by one.
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_absa} : 33'd0);

  // Restoring-division step. The remainder stays below |B| <= 2^31, so bit 31
  // of r_hi is always zero. The shifted value therefore fits in 32 bits.
  assign w_dshift = {r_hi[30:0], r_lo[31]};
  assign w_ge     = (w_dshift >= r_absb);
  assign w_dsub   = w_dshift - r_absb;

  assign w_pneg  = r_sa ^ r_sb;
  assign w_sprod = w_pneg ? (~{r_hi, r_lo} + 64'd1) : {r_hi, r_lo};
  assign w_quo   = w_pneg ? (~r_lo + 32'd1) : r_lo;
  assign w_rem   = r_sa ? (~r_hi + 32'd1) : r_hi;

  always_comb begin
    w_res = 32'd0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    if (r_dz || r_ill) begin
      w_res = 32'd0;
    end else if (w_is_mul) begin
      w_res = w_sprod[31:0];
      w_v   = (w_sprod[63:31] != {33{w_sprod[31]}});
      w_c   = |r_hi;
    end else if (w_is_div) begin
      w_res = w_quo;
      // Only a positive quotient of magnitude 2^31 can leave the range, which happens for MIN / -1.
      w_v   = ~w_pneg & r_lo[31];
    end else begin
      w_res = w_rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_op     <= 4'd0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_absa   <= 32'd0;
      r_absb   <= 32'd0;
      r_dz     <= 1'b0;
      r_ill    <= 1'b0;
      r_cnt    <= 6'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_v      <= 1'b0;
      r_c      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= reg1;
            r_b     <= reg2;
            r_op    <= operation;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_sa    <= r_a[31];
          r_sb    <= r_b[31];
          r_absa  <= w_absa;
          r_absb  <= w_absb;
          r_dz    <= (r_b == 32'd0) && (w_is_div || w_is_mod);
          r_ill   <= !(w_is_mul || w_is_div || w_is_mod);
          r_cnt   <= 6'd0;
          r_hi    <= 32'd0;
          r_lo    <= w_is_mul ? w_absb : w_absa;
          r_state <= S_CALC;
        end
        S_CALC: begin
          if (w_is_mul) begin
            {r_hi, r_lo} <= {w_madd, r_lo[31:1]};
          end else if (w_ge) begin
            r_hi <= w_dsub;
            r_lo <= {r_lo[30:0], 1'b1};
          end else begin
            r_hi <= w_dshift;
            r_lo <= {r_lo[30:0], 1'b0};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= w_res;
          r_z      <= (w_res == 32'd0);
          r_n      <= w_res[31];
          r_v      <= w_v;
          r_c      <= w_c;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign z_flag = r_z;
  assign n_flag = r_n;
  assign v_flag = r_v;
  assign c_flag = r_c;

endmodule
